// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the io_bridge word-to-byte bus bridge.
package io_bridge_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int DATA_WIDTH     = 32;
    localparam int BR_BEATS       = 4;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_XFER = 2'd1,
        BR_DONE = 2'd2
    } br_state_t;

endpackage

// File: rtl/io_bridge_if.sv
// CPU word port and byte-wide peripheral bus as seen by io_bridge (slave) and its environment (master).
interface io_bridge_if
    import io_bridge_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              busy;
    logic [ADDR_W-1:0] p_addr;
    logic [7:0]        p_wdata;
    logic [7:0]        p_rdata;
    logic              p_cs_;
    logic              p_rw_;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, p_rdata,
        input  cpu_rdata, cpu_ack, busy, p_addr, p_wdata, p_cs_, p_rw_
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, p_rdata,
        output cpu_rdata, cpu_ack, busy, p_addr, p_wdata, p_cs_, p_rw_
    );
endinterface

// File: rtl/io_byte_lane.sv
// Byte-lane steering: picks the outgoing write byte and merges a read byte into the assembled word.
module io_byte_lane #(
    parameter int BEATS = 4,
    parameter int SEL_W = $clog2(BEATS)
) (
    input  logic [8*BEATS-1:0] wword,
    input  logic [SEL_W-1:0]   wsel,
    output logic [7:0]         wbyte,
    input  logic [8*BEATS-1:0] rd_word,
    input  logic [SEL_W-1:0]   rd_sel,
    input  logic [7:0]         rd_byte,
    input  logic               byte_mode,
    output logic [8*BEATS-1:0] rd_merged
);
    assign wbyte = wword[8*wsel +: 8];

    // Byte loads replace the whole word so the upper lanes read as zero.
    always_comb begin
        rd_merged = rd_word;
        rd_merged[8*rd_sel +: 8] = rd_byte;
        if (byte_mode) begin
            rd_merged = {{(8*BEATS-8){1'b0}}, rd_byte};
        end
    end
endmodule

// File: rtl/io_bridge.sv
// Splits a CPU word load/store into little-endian byte beats on the peripheral bus.
// Optional single-byte accesses are enabled by defining IO_BRIDGE_BYTE_EN.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int BEATS  = BR_BEATS
) (
    input logic       clk,
    input logic       rst_,
    io_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int W     = 8 * BEATS;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEATS - 1);

    br_state_t         state_q, state_n;
    logic [CNT_W-1:0]  beat_q, beat_n;
    logic              we_q, we_n;
    logic              byte_q, byte_n;
    logic [W-1:0]      wdata_q, wdata_n;
    logic [ADDR_W-1:0] p_addr_q, p_addr_n;
    logic [7:0]        p_wdata_q, p_wdata_n;
    logic              p_cs_q, p_cs_n;
    logic              p_rw_q, p_rw_n;
    logic [W-1:0]      rdata_q, rdata_n;
    logic              ack_q, ack_n;
    logic              busy_q, busy_n;

    logic              req_byte;
    logic              last_beat;
    logic [CNT_W-1:0]  lane_wsel;
    logic [W-1:0]      lane_wword;
    logic [7:0]        lane_wbyte;
    logic [W-1:0]      lane_rmerged;

`ifdef IO_BRIDGE_BYTE_EN
    assign req_byte = bus.cpu_size;
`else
    logic unused_size;
    assign unused_size = bus.cpu_size;
    assign req_byte    = 1'b0;
`endif

    assign last_beat  = byte_q || (beat_q == CNT_W'(BEATS - 1));
    // In IDLE the first byte comes straight from the request; later beats from the latched word.
    assign lane_wsel  = (state_q == BR_IDLE) ? '0 : beat_q + CNT_W'(1);
    assign lane_wword = (state_q == BR_IDLE) ? bus.cpu_wdata : wdata_q;

    io_byte_lane #(.BEATS(BEATS), .SEL_W(CNT_W)) u_lane (
        .wword     (lane_wword),
        .wsel      (lane_wsel),
        .wbyte     (lane_wbyte),
        .rd_word   (rdata_q),
        .rd_sel    (beat_q),
        .rd_byte   (bus.p_rdata),
        .byte_mode (byte_q),
        .rd_merged (lane_rmerged)
    );

    always_comb begin
        state_n   = state_q;
        beat_n    = beat_q;
        we_n      = we_q;
        byte_n    = byte_q;
        wdata_n   = wdata_q;
        p_addr_n  = p_addr_q;
        p_wdata_n = p_wdata_q;
        p_cs_n    = 1'b1;
        p_rw_n    = 1'b1;
        rdata_n   = rdata_q;
        ack_n     = 1'b0;
        busy_n    = busy_q;

        unique case (state_q)
            BR_IDLE: begin
                if (bus.cpu_req) begin
                    state_n   = BR_XFER;
                    busy_n    = 1'b1;
                    we_n      = bus.cpu_we;
                    byte_n    = req_byte;
                    wdata_n   = bus.cpu_wdata;
                    beat_n    = '0;
                    p_cs_n    = 1'b0;
                    p_rw_n    = ~bus.cpu_we;
                    p_addr_n  = req_byte ? bus.cpu_addr : (bus.cpu_addr & ALIGN_MASK);
                    p_wdata_n = lane_wbyte;
                end
            end
            BR_XFER: begin
                if (!we_q) begin
                    rdata_n = lane_rmerged;
                end
                if (last_beat) begin
                    state_n = BR_DONE;
                    ack_n   = 1'b1;
                end else begin
                    beat_n    = beat_q + CNT_W'(1);
                    p_cs_n    = 1'b0;
                    p_rw_n    = ~we_q;
                    p_addr_n  = p_addr_q + ADDR_W'(1);
                    p_wdata_n = lane_wbyte;
                end
            end
            BR_DONE: begin
                state_n = BR_IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q   <= BR_IDLE;
            beat_q    <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            wdata_q   <= '0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            p_cs_q    <= 1'b1;
            p_rw_q    <= 1'b1;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            beat_q    <= beat_n;
            we_q      <= we_n;
            byte_q    <= byte_n;
            wdata_q   <= wdata_n;
            p_addr_q  <= p_addr_n;
            p_wdata_q <= p_wdata_n;
            p_cs_q    <= p_cs_n;
            p_rw_q    <= p_rw_n;
            rdata_q   <= rdata_n;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.busy      = busy_q;
    assign bus.p_addr    = p_addr_q;
    assign bus.p_wdata   = p_wdata_q;
    assign bus.p_cs_     = p_cs_q;
    assign bus.p_rw_     = p_rw_q;
endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a byte-memory peripheral model; byte tests need IO_BRIDGE_BYTE_EN.
module tb_io_bridge;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;

    logic [7:0]  mem [256];
    logic [16:0] beats [$];   // {rw_, addr, wdata} for each cycle with p_cs_ low

    io_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    io_bridge #(.ADDR_W(8), .BEATS(4)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.p_rdata = mem[bus.p_addr];

    always @(negedge clk) begin
        if (bus.p_cs_ === 1'b0) begin
            beats.push_back({bus.p_rw_, bus.p_addr, bus.p_wdata});
            if (bus.p_rw_ === 1'b0) mem[bus.p_addr] = bus.p_wdata;
        end
        if (bus.cpu_ack === 1'b1) ack_cnt++;
    end

    task automatic access(input logic we, input logic size, input logic [7:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int ack_cyc);
        ack_cyc = -1;
        rdata   = 'x;
        @(negedge clk);
        beats.delete();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_size  = size;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1) begin
                ack_cyc = n;
                rdata   = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.p_cs_, bus.p_rw_, bus.cpu_ack, bus.busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl: cs_/rw_/ack/busy got %b want 1100",
                     {bus.p_cs_, bus.p_rw_, bus.cpu_ack, bus.busy});
        end
        checks++;
        if ({bus.p_addr, bus.p_wdata, bus.cpu_rdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: addr/wdata/rdata got %h want 0",
                     {bus.p_addr, bus.p_wdata, bus.cpu_rdata});
        end
        rst_ = 1'b1;
    endtask

    task automatic test_word_store();
        logic [31:0] rd;
        int          ac;
        access(1'b1, 1'b0, 8'h04, 32'h0000_0001, rd, ac);
        checks++;
        if (ac !== 5) begin
            errors++;
            $display("FAIL store_ack_cycle: got %0d want 5", ac);
        end
        checks++;
        if (beats.size() !== 4) begin
            errors++;
            $display("FAIL store_beat_count: got %0d want 4", beats.size());
        end
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            checks++;
            if (beats[k] !== {1'b0, 8'(4 + k), (k == 0) ? 8'h01 : 8'h00}) begin
                errors++;
                $display("FAIL store_beat%0d: got %h want %h", k, beats[k],
                         {1'b0, 8'(4 + k), (k == 0) ? 8'h01 : 8'h00});
            end
        end
        // unaligned address is forced down to the word base 0x08
        access(1'b1, 1'b0, 8'h0A, 32'hDEAD_BEEF, rd, ac);
        checks++;
        if ({mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]} !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_align: got %h want deadbeef",
                     {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]});
        end
    endtask

    task automatic test_word_load();
        logic [31:0] rd;
        int          ac;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h1234_5678;
        access(1'b0, 1'b0, 8'h00, 32'hFFFF_FFFF, rd, ac);
        checks++;
        if (rd !== 32'h1234_5678 || ac !== 5) begin
            errors++;
            $display("FAIL load_at_0: rdata %h cyc %0d want 12345678 cyc 5", rd, ac);
        end
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            checks++;
            if (beats[k][16:8] !== {1'b1, 8'(k)}) begin
                errors++;
                $display("FAIL load_beat%0d: rw_/addr got %h want %h", k, beats[k][16:8], {1'b1, 8'(k)});
            end
        end
        {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'h4433_2211;
        access(1'b0, 1'b0, 8'hFE, 32'h0, rd, ac);
        checks++;
        if (rd !== 32'h4433_2211) begin
            errors++;
            $display("FAIL load_at_fe: rdata %h want 44332211", rd);
        end
        checks++;
        if (beats.size() !== 4 || beats[0][15:8] !== 8'hFC || beats[3][15:8] !== 8'hFF) begin
            errors++;
            $display("FAIL load_fe_addrs: n=%0d first %h last %h want 4 fc ff", beats.size(),
                     beats.size() > 0 ? beats[0][15:8] : 8'hxx, beats.size() > 3 ? beats[3][15:8] : 8'hxx);
        end
        // a store leaves previously loaded data untouched
        access(1'b1, 1'b0, 8'h40, 32'hCAFE_F00D, rd, ac);
        checks++;
        if (rd !== 32'h4433_2211) begin
            errors++;
            $display("FAIL rdata_hold: got %h want 44332211", rd);
        end
    endtask

    task automatic test_size();
        logic [31:0] rd;
        int          ac;
        mem[8'hFF] = 8'hA5;
`ifdef IO_BRIDGE_BYTE_EN
        access(1'b0, 1'b1, 8'hFF, 32'h0, rd, ac);
        checks++;
        if (rd !== 32'h0000_00A5 || ac !== 2) begin
            errors++;
            $display("FAIL byte_load: rdata %h cyc %0d want 000000a5 cyc 2", rd, ac);
        end
        checks++;
        if (beats.size() !== 1 || beats[0][16:8] !== 9'h1FF) begin
            errors++;
            $display("FAIL byte_load_beat: n=%0d want 1 beat at ff", beats.size());
        end
        mem[8'h30] = 8'h00;
        access(1'b1, 1'b1, 8'h31, 32'h9988_7766, rd, ac);
        checks++;
        if ({mem[8'h31], mem[8'h30]} !== 16'h6600 || ac !== 2 || beats.size() !== 1) begin
            errors++;
            $display("FAIL byte_store: mem %h cyc %0d n=%0d want 6600 cyc 2 n=1",
                     {mem[8'h31], mem[8'h30]}, ac, beats.size());
        end
`else
        access(1'b0, 1'b1, 8'hFF, 32'h0, rd, ac);
        checks++;
        if (rd !== 32'hA533_2211 || ac !== 5 || beats.size() !== 4) begin
            errors++;
            $display("FAIL size_ignored: rdata %h cyc %0d n=%0d want a5332211 cyc 5 n=4",
                     rd, ac, beats.size());
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] cs_mask = '0;
        logic [15:0] ack_mask = '0;
        logic [15:0] busy_mask = '0;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h0BAD_F00D;
        @(negedge clk);
        beats.delete();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_size = 1'b0;
        bus.cpu_addr = 8'h00;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            cs_mask[n]   = (bus.p_cs_ === 1'b0);
            ack_mask[n]  = (bus.cpu_ack === 1'b1);
            busy_mask[n] = (bus.busy === 1'b1);
            if (n == 11) bus.cpu_req = 1'b0;
        end
        checks++;
        if (cs_mask !== 16'h079E) begin
            errors++;
            $display("FAIL b2b_cs_mask: got %h want 079e", cs_mask);
        end
        checks++;
        if (ack_mask !== 16'h0820) begin
            errors++;
            $display("FAIL b2b_ack_mask: got %h want 0820", ack_mask);
        end
        checks++;
        if (busy_mask !== 16'h0FBE) begin
            errors++;
            $display("FAIL b2b_busy_mask: got %h want 0fbe", busy_mask);
        end
        checks++;
        if (beats.size() !== 8) begin
            errors++;
            $display("FAIL b2b_beats: got %0d want 8", beats.size());
        end
    endtask

    task automatic test_reset_mid();
        int          acks_before;
        logic [31:0] rd;
        int          ac;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h0;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_size  = 1'b0;
        bus.cpu_addr  = 8'h20;
        bus.cpu_wdata = 32'hAABB_CCDD;
        repeat (2) @(negedge clk);
        rst_        = 1'b0;
        bus.cpu_req = 1'b0;
        acks_before = ack_cnt;
        @(negedge clk);
        checks++;
        if ({bus.p_cs_, bus.busy, bus.cpu_ack} !== 3'b100 || bus.cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: cs_/busy/ack %b rdata %h want 100 0",
                     {bus.p_cs_, bus.busy, bus.cpu_ack}, bus.cpu_rdata);
        end
        @(negedge clk);
        rst_ = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (ack_cnt !== acks_before) begin
            errors++;
            $display("FAIL mid_reset_ack: got %0d acks want 0", ack_cnt - acks_before);
        end
        checks++;
        if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== 32'h0000_CCDD) begin
            errors++;
            $display("FAIL partial_store: got %h want 0000ccdd",
                     {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]});
        end
        access(1'b0, 1'b0, 8'h20, 32'h0, rd, ac);
        checks++;
        if (rd !== 32'h0000_CCDD || ac !== 5) begin
            errors++;
            $display("FAIL post_reset_load: rdata %h cyc %0d want 0000ccdd cyc 5", rd, ac);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_size  = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 32'h0;
        test_reset();
        test_word_store();
        test_word_load();
        test_size();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
